bank_xbar_rtn_rob: RTL and testbench
====================================

Name: bank_xbar_rtn_rob

Overview:
- Sits directly downstream of bank_sram_controller, on the sc_xbar_* return path.
- Captures read-return beats, which the SRAM controller can produce out of order. Each beat is tagged by channel and ROB number.
- Re-orders the beats per channel into strict rob_num order and presents them to the xbar on one valid/ready port per channel.
- Returns one credit pulse per drained beat to the ISU, on the xbar_isu_chN_credit inputs of bank_isu_top.

Parameters:
- DATA_W, 128, width of one return beat in bits.
- ROB_DEPTH, 8, entries per channel. Fixed at 2^3 to match rob_num width; other values are not supported.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- sc_xbar_valid_i  input  1  return beat valid
- sc_xbar_ready_o  output  1  return beat accepted
- sc_xbar_channel_id_i  input  2  destination channel (0..2 legal)
- sc_xbar_rob_num_i  input  3  ROB slot within channel
- sc_xbar_data_i  input  DATA_W  beat data
- xbar_chN_rtn_valid_o  output  1  (N=0,1,2) in-order beat available
- xbar_chN_rtn_ready_i  input  1  (N=0,1,2) xbar consumes beat
- xbar_chN_rtn_rob_num_o  output  3  (N=0,1,2) slot being presented (equals head pointer)
- xbar_chN_rtn_data_o  output  DATA_W  (N=0,1,2) beat data
- xbar_isu_chN_credit_o  output  1  (N=0,1,2) one-cycle credit pulse per drained beat
- rob_err_o  output  1  sticky error flag

Behaviour:
- One clock. Reset is asynchronous and active-high on rst_i; clk_i and rst_i are the port names.
- State per channel c:
  - vld[c][0..7], cleared on reset.
  - data[c][0..7], no reset.
  - head[c], 3 bits, reset 0.
- Reset values:
  - all valid/credit outputs 0, rob_err_o 0, rob_num outputs 0.
  - sc_xbar_ready_o forced 0 while rst_i=1.
  - data outputs don't-care.
- Input acceptance, with ch = channel_id and r = rob_num:
  - sc_xbar_ready_o = ~rst_i & (ch==3 | ~vld[ch][r]). It is combinational from current state only; no same-cycle bypass from a drain.
  - Handshake with ch<3: vld[ch][r] is set and data is stored at the clock edge. The entry is visible on the output no earlier than the next cycle, so input-to-output latency is 1 cycle minimum.
  - Handshake with ch==3: beat dropped, rob_err_o set. It stays set until reset.
  - If vld[ch][r] is already 1, ready is 0 (collision stall). The upstream holds the beat until the slot drains.
- Output, per channel:
  - xbar_chN_rtn_valid_o = vld[N][head[N]].
  - data_o = data[N][head[N]], rob_num_o = head[N].
  - Both are combinational from registers and stable while valid & ~ready.
  - Later slots that are valid while the head slot is empty do not drain; strict in-order.
- Drain, when valid & ready on channel N:
  - vld[N][head] is cleared and head[N] increments, wrapping 7 -> 0.
  - xbar_isu_chN_credit_o is 1 for exactly the next cycle (registered). Back-to-back drains give a continuous high credit, one cycle per beat.
- Simultaneous events:
  - Fill of channel A and drain of channel B in the same cycle are independent.
  - Fill of slot s and drain of a different slot of the same channel in the same cycle both take effect.
  - Fill of the head slot while it is still valid stalls (rule above).
- Throughput: one fill per cycle and one drain per channel per cycle.
- Reset mid-operation: all stored beats are discarded, heads return to 0, and pending credit pulses are cancelled. The ISU re-initialises its credit counters on the same reset.

Test Plan:
- In order: ch0 rob 0,1,2 on consecutive cycles, ready held 1. Required: ch0 valid from cycle 2 onward, rob_num_o 0,1,2, data matches, 3 credit pulses, each one cycle after its drain.
- Out of order: ch1 rob 2, then rob 1, then rob 0. Required: ch1 valid stays 0 until rob 0 has been written. Then data drains in the order 0,1,2 on 3 consecutive cycles.
- Backpressure and collision: fill ch2 rob 0..7 with ready_i=0. Then send ch2 rob 0 again. Required:
  - sc_xbar_ready_o=0, valid and data stable.
  - Raise ready_i for 1 cycle: rob 0 drains, and the stalled beat is accepted the following cycle.
- Wrap: stream 20 beats to ch0 in order. Required: head wraps 7->0 twice, rob_num_o sequence 0..7,0..7,0..3, 20 credit pulses, no error.
- Illegal channel: channel_id=3 with valid=1. Required: ready=1, no output valid on any channel, rob_err_o=1 from the next cycle until reset.
- Reset mid-op: hold 3 beats on ch0, drain 1 (credit pending), assert rst_i asynchronously. Required: all valids and credits drop immediately, head=0, and there is no credit pulse after release.

Source files
------------

// File: rtl/bank_xbar_rtn_rob.sv
// bank_xbar_rtn_rob: per-channel reorder buffer on the SRAM controller read-return path.
// Beats arrive tagged by channel and ROB slot, possibly out of order. Each channel
// drains in strict rob_num order on its own valid/ready port. Every drained beat
// returns one registered credit pulse to the ISU.
module bank_xbar_rtn_rob #(
  parameter int DATA_W    = 128,
  parameter int ROB_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sc_xbar_valid_i,
  output logic              sc_xbar_ready_o,
  input  logic [1:0]        sc_xbar_channel_id_i,
  input  logic [2:0]        sc_xbar_rob_num_i,
  input  logic [DATA_W-1:0] sc_xbar_data_i,
  output logic              xbar_ch0_rtn_valid_o,
  input  logic              xbar_ch0_rtn_ready_i,
  output logic [2:0]        xbar_ch0_rtn_rob_num_o,
  output logic [DATA_W-1:0] xbar_ch0_rtn_data_o,
  output logic              xbar_ch1_rtn_valid_o,
  input  logic              xbar_ch1_rtn_ready_i,
  output logic [2:0]        xbar_ch1_rtn_rob_num_o,
  output logic [DATA_W-1:0] xbar_ch1_rtn_data_o,
  output logic              xbar_ch2_rtn_valid_o,
  input  logic              xbar_ch2_rtn_ready_i,
  output logic [2:0]        xbar_ch2_rtn_rob_num_o,
  output logic [DATA_W-1:0] xbar_ch2_rtn_data_o,
  output logic              xbar_isu_ch0_credit_o,
  output logic              xbar_isu_ch1_credit_o,
  output logic              xbar_isu_ch2_credit_o,
  output logic              rob_err_o
);
  localparam int NCH = 3;

  logic [NCH-1:0]    rtn_ready;
  logic [NCH-1:0]    rtn_valid;
  logic [2:0]        rtn_rob  [NCH];
  logic [DATA_W-1:0] rtn_data [NCH];
  logic [NCH-1:0]    credit;
  // Index 3 is the illegal channel: never busy, so its beats are taken and dropped.
  logic [3:0]        slot_busy;
  logic              fire;
  logic              err_q, err_d;

  assign rtn_ready    = {xbar_ch2_rtn_ready_i, xbar_ch1_rtn_ready_i, xbar_ch0_rtn_ready_i};
  assign slot_busy[3] = 1'b0;

  // Ready looks only at current slot occupancy; a drain this cycle does not free
  // the slot for a fill until the next cycle.
  assign sc_xbar_ready_o = ~rst_i & ~slot_busy[sc_xbar_channel_id_i];
  assign fire            = sc_xbar_valid_i & sc_xbar_ready_o;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [ROB_DEPTH-1:0] vld_q, vld_d;
    logic [2:0]           head_q, head_d;
    logic                 credit_q, credit_d;
    logic                 fill, drain;
    logic [DATA_W-1:0]    mem_q [ROB_DEPTH];

    assign fill          = fire & (sc_xbar_channel_id_i == 2'(gi));
    assign drain         = vld_q[head_q] & rtn_ready[gi];
    assign slot_busy[gi] = vld_q[sc_xbar_rob_num_i];

    // Next state: drain retires the head slot, fill marks the addressed slot.
    // A fill never targets a valid slot, so the two never touch the same bit.
    always_comb begin
      vld_d    = vld_q;
      head_d   = head_q;
      credit_d = drain;
      if (drain) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + 3'd1;
      end
      if (fill) begin
        vld_d[sc_xbar_rob_num_i] = 1'b1;
      end
    end

    // Slot valids, head pointer and credit pulse; reset discards everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q    <= '0;
        head_q   <= 3'd0;
        credit_q <= 1'b0;
      end else begin
        vld_q    <= vld_d;
        head_q   <= head_d;
        credit_q <= credit_d;
      end
    end

    // Beat payload storage; contents are qualified by vld_q so no reset is needed.
    always_ff @(posedge clk_i) begin
      if (fill) begin
        mem_q[sc_xbar_rob_num_i] <= sc_xbar_data_i;
      end
    end

    assign rtn_valid[gi] = vld_q[head_q];
    assign rtn_rob[gi]   = head_q;
    assign rtn_data[gi]  = mem_q[head_q];
    assign credit[gi]    = credit_q;
  end

  // Error flag becomes sticky on any beat addressed to channel 3.
  always_comb begin
    err_d = err_q | (fire & (sc_xbar_channel_id_i == 2'd3));
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign xbar_ch0_rtn_valid_o   = rtn_valid[0];
  assign xbar_ch0_rtn_rob_num_o = rtn_rob[0];
  assign xbar_ch0_rtn_data_o    = rtn_data[0];
  assign xbar_ch1_rtn_valid_o   = rtn_valid[1];
  assign xbar_ch1_rtn_rob_num_o = rtn_rob[1];
  assign xbar_ch1_rtn_data_o    = rtn_data[1];
  assign xbar_ch2_rtn_valid_o   = rtn_valid[2];
  assign xbar_ch2_rtn_rob_num_o = rtn_rob[2];
  assign xbar_ch2_rtn_data_o    = rtn_data[2];
  assign xbar_isu_ch0_credit_o  = credit[0];
  assign xbar_isu_ch1_credit_o  = credit[1];
  assign xbar_isu_ch2_credit_o  = credit[2];
  assign rob_err_o              = err_q;

endmodule

// File: tb/tb_bank_xbar_rtn_rob.sv
// Testbench for bank_xbar_rtn_rob: directed scenarios plus randomized traffic
// checked against a behavioural reorder model.
module tb_bank_xbar_rtn_rob;
  localparam int DW = 128;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          sc_valid = 1'b0;
  logic          sc_ready;
  logic [1:0]    sc_ch = 2'd0;
  logic [2:0]    sc_rob = 3'd0;
  logic [DW-1:0] sc_data = '0;
  logic [2:0]    rv;
  logic [2:0]    rr = 3'b000;
  logic [2:0]    cr;
  logic [2:0]    rob_o [3];
  logic [DW-1:0] dat_o [3];
  logic          err;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: per channel a set of parked beats and an ever-growing
  // sequence number of the next beat owed to the xbar (slot = seq mod 8).
  bit            m_have [3][8];
  logic [DW-1:0] m_dat  [3][8];
  int            m_head [3];
  bit            m_cred [3];
  bit            m_err;
  int            obs_cred [3];
  bit            last_acc;

  always #5 clk_i = ~clk_i;

  bank_xbar_rtn_rob #(.DATA_W(DW), .ROB_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sc_xbar_valid_i(sc_valid), .sc_xbar_ready_o(sc_ready),
    .sc_xbar_channel_id_i(sc_ch), .sc_xbar_rob_num_i(sc_rob), .sc_xbar_data_i(sc_data),
    .xbar_ch0_rtn_valid_o(rv[0]), .xbar_ch0_rtn_ready_i(rr[0]),
    .xbar_ch0_rtn_rob_num_o(rob_o[0]), .xbar_ch0_rtn_data_o(dat_o[0]),
    .xbar_ch1_rtn_valid_o(rv[1]), .xbar_ch1_rtn_ready_i(rr[1]),
    .xbar_ch1_rtn_rob_num_o(rob_o[1]), .xbar_ch1_rtn_data_o(dat_o[1]),
    .xbar_ch2_rtn_valid_o(rv[2]), .xbar_ch2_rtn_ready_i(rr[2]),
    .xbar_ch2_rtn_rob_num_o(rob_o[2]), .xbar_ch2_rtn_data_o(dat_o[2]),
    .xbar_isu_ch0_credit_o(cr[0]), .xbar_isu_ch1_credit_o(cr[1]),
    .xbar_isu_ch2_credit_o(cr[2]), .rob_err_o(err)
  );

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 8; s++) m_have[c][s] = 1'b0;
      m_head[c] = 0;
      m_cred[c] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b1; sc_valid = 1'b0; rr = 3'b000;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  // One clock: predict the handshake and drains from the model, cross the edge,
  // update the model, and return at the following falling edge.
  task automatic step();
    bit acc;
    bit drn [3];
    if (sc_ch == 2'd3) acc = sc_valid;
    else acc = sc_valid && !m_have[sc_ch][sc_rob];
    for (int c = 0; c < 3; c++) drn[c] = m_have[c][m_head[c] % 8] && rr[c];
    @(posedge clk_i);
    for (int c = 0; c < 3; c++) begin
      m_cred[c] = drn[c];
      if (drn[c]) begin
        $display("%0t drain  ch%0d rob %0d", $time, c, m_head[c] % 8);
        m_have[c][m_head[c] % 8] = 1'b0;
        m_head[c]++;
      end
    end
    if (acc) begin
      $display("%0t accept ch%0d rob %0d", $time, sc_ch, sc_rob);
      if (sc_ch == 2'd3) m_err = 1'b1;
      else begin
        m_have[sc_ch][sc_rob] = 1'b1;
        m_dat[sc_ch][sc_rob]  = sc_data;
      end
    end
    last_acc = acc;
    @(negedge clk_i);
    for (int c = 0; c < 3; c++) obs_cred[c] += int'(cr[c]);
  endtask

  task automatic test_reset();
    sc_valid = 1'b1; sc_ch = 2'd0; sc_rob = 3'd0;
    repeat (2) @(negedge clk_i);
    n_total++; if (sc_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", sc_ready); else n_pass++;
    n_total++; if (rv !== 3'b000) $display("FAIL reset_valid got %b exp 000", rv); else n_pass++;
    n_total++; if (cr !== 3'b000) $display("FAIL reset_credit got %b exp 000", cr); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_total++; if (rob_o[c] !== 3'd0) $display("FAIL reset_rob ch%0d got %0d exp 0", c, rob_o[c]); else n_pass++;
    end
    sc_valid = 1'b0; rst_i = 1'b0; model_reset();
    #1;
    n_total++; if (sc_ready !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", sc_ready); else n_pass++;
    @(negedge clk_i);
  endtask

  task automatic test_in_order();
    logic [DW-1:0] d [3];
    int c0;
    c0 = obs_cred[0];
    rr = 3'b001;
    n_total++; if (rv[0] !== 1'b0) $display("FAIL io_pre_valid got %b exp 0", rv[0]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      sc_valid = 1'b1; sc_ch = 2'd0; sc_rob = 3'(i); d[i] = rnd_data(); sc_data = d[i];
      step();
      n_total++; if (rv[0] !== 1'b1) $display("FAIL io_valid i=%0d got %b exp 1", i, rv[0]); else n_pass++;
      n_total++; if (rob_o[0] !== 3'(i)) $display("FAIL io_rob got %0d exp %0d", rob_o[0], i); else n_pass++;
      n_total++; if (dat_o[0] !== d[i]) $display("FAIL io_data i=%0d got %h exp %h", i, dat_o[0], d[i]); else n_pass++;
      n_total++; if (cr[0] !== (i > 0)) $display("FAIL io_credit i=%0d got %b exp %b", i, cr[0], i > 0); else n_pass++;
    end
    sc_valid = 1'b0;
    step();
    n_total++; if (rv[0] !== 1'b0) $display("FAIL io_empty got %b exp 0", rv[0]); else n_pass++;
    n_total++; if (cr[0] !== 1'b1) $display("FAIL io_last_credit got %b exp 1", cr[0]); else n_pass++;
    step();
    n_total++; if (obs_cred[0] - c0 !== 3) $display("FAIL io_credits got %0d exp 3", obs_cred[0] - c0); else n_pass++;
    rr = 3'b000;
  endtask

  task automatic test_out_of_order();
    logic [DW-1:0] d [3];
    int c1;
    c1 = obs_cred[1];
    rr = 3'b010;
    for (int k = 2; k >= 0; k--) begin
      sc_valid = 1'b1; sc_ch = 2'd1; sc_rob = 3'(k); d[k] = rnd_data(); sc_data = d[k];
      step();
      n_total++; if (rv[1] !== (k == 0)) $display("FAIL ooo_valid after rob %0d got %b exp %b", k, rv[1], k == 0); else n_pass++;
    end
    sc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_total++; if (rv[1] !== 1'b1 || rob_o[1] !== 3'(k)) $display("FAIL ooo_order got v=%b rob=%0d exp v=1 rob=%0d", rv[1], rob_o[1], k); else n_pass++;
      n_total++; if (dat_o[1] !== d[k]) $display("FAIL ooo_data rob %0d got %h exp %h", k, dat_o[1], d[k]); else n_pass++;
      step();
    end
    n_total++; if (rv[1] !== 1'b0) $display("FAIL ooo_empty got %b exp 0", rv[1]); else n_pass++;
    step();
    n_total++; if (obs_cred[1] - c1 !== 3) $display("FAIL ooo_credits got %0d exp 3", obs_cred[1] - c1); else n_pass++;
    rr = 3'b000;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [8];
    logic [DW-1:0] x;
    logic [DW-1:0] ed;
    rr = 3'b000;
    for (int i = 0; i < 8; i++) begin
      sc_valid = 1'b1; sc_ch = 2'd2; sc_rob = 3'(i); d[i] = rnd_data(); sc_data = d[i];
      #1;
      n_total++; if (sc_ready !== 1'b1) $display("FAIL bp_fill_ready rob %0d got %b exp 1", i, sc_ready); else n_pass++;
      step();
    end
    x = rnd_data(); sc_rob = 3'd0; sc_data = x;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (sc_ready !== 1'b0) $display("FAIL bp_collision_ready got %b exp 0", sc_ready); else n_pass++;
      n_total++; if (rv[2] !== 1'b1 || rob_o[2] !== 3'd0) $display("FAIL bp_hold got v=%b rob=%0d exp v=1 rob=0", rv[2], rob_o[2]); else n_pass++;
      n_total++; if (dat_o[2] !== d[0]) $display("FAIL bp_hold_data got %h exp %h", dat_o[2], d[0]); else n_pass++;
      step();
    end
    rr[2] = 1'b1;
    step();
    rr[2] = 1'b0;
    #1;
    n_total++; if (sc_ready !== 1'b1) $display("FAIL bp_freed_ready got %b exp 1", sc_ready); else n_pass++;
    n_total++; if (cr[2] !== 1'b1) $display("FAIL bp_credit got %b exp 1", cr[2]); else n_pass++;
    n_total++; if (rob_o[2] !== 3'd1 || dat_o[2] !== d[1]) $display("FAIL bp_next got rob=%0d exp 1", rob_o[2]); else n_pass++;
    step();
    sc_valid = 1'b0;
    #1;
    n_total++; if (sc_ready !== 1'b0) $display("FAIL bp_refilled_ready got %b exp 0", sc_ready); else n_pass++;
    rr[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      ed = (k == 8) ? x : d[k];
      n_total++; if (rv[2] !== 1'b1 || rob_o[2] !== 3'(k % 8)) $display("FAIL bp_drain got v=%b rob=%0d exp v=1 rob=%0d", rv[2], rob_o[2], k % 8); else n_pass++;
      n_total++; if (dat_o[2] !== ed) $display("FAIL bp_drain_data rob %0d got %h exp %h", k % 8, dat_o[2], ed); else n_pass++;
      step();
    end
    n_total++; if (rv[2] !== 1'b0) $display("FAIL bp_empty got %b exp 0", rv[2]); else n_pass++;
    rr = 3'b000;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d [20];
    int c0;
    apply_reset();
    c0 = obs_cred[0];
    rr = 3'b001;
    for (int i = 0; i < 20; i++) begin
      sc_valid = 1'b1; sc_ch = 2'd0; sc_rob = 3'(i % 8); d[i] = rnd_data(); sc_data = d[i];
      step();
      n_total++; if (rv[0] !== 1'b1 || rob_o[0] !== 3'(i % 8)) $display("FAIL wrap_rob i=%0d got v=%b rob=%0d exp v=1 rob=%0d", i, rv[0], rob_o[0], i % 8); else n_pass++;
      n_total++; if (dat_o[0] !== d[i]) $display("FAIL wrap_data i=%0d got %h exp %h", i, dat_o[0], d[i]); else n_pass++;
      n_total++; if (cr[0] !== (i > 0)) $display("FAIL wrap_credit i=%0d got %b exp %b", i, cr[0], i > 0); else n_pass++;
    end
    sc_valid = 1'b0;
    step();
    step();
    n_total++; if (obs_cred[0] - c0 !== 20) $display("FAIL wrap_credits got %0d exp 20", obs_cred[0] - c0); else n_pass++;
    n_total++; if (rob_o[0] !== 3'd4 || rv[0] !== 1'b0) $display("FAIL wrap_final got rob=%0d v=%b exp rob=4 v=0", rob_o[0], rv[0]); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL wrap_err got %b exp 0", err); else n_pass++;
    rr = 3'b000;
  endtask

  task automatic test_illegal();
    rr = 3'b111;
    sc_valid = 1'b1; sc_ch = 2'd3; sc_rob = 3'($urandom_range(0, 7)); sc_data = rnd_data();
    #1;
    n_total++; if (sc_ready !== 1'b1) $display("FAIL ill_ready got %b exp 1", sc_ready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL ill_err_before got %b exp 0", err); else n_pass++;
    step();
    sc_valid = 1'b0; sc_ch = 2'd0;
    n_total++; if (err !== 1'b1) $display("FAIL ill_err got %b exp 1", err); else n_pass++;
    n_total++; if (rv !== 3'b000) $display("FAIL ill_valid got %b exp 000", rv); else n_pass++;
    repeat (3) step();
    n_total++; if (err !== 1'b1) $display("FAIL ill_err_sticky got %b exp 1", err); else n_pass++;
    rr = 3'b000;
  endtask

  task automatic test_random();
    int chn;
    bit exp_rdy;
    last_acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (last_acc || !sc_valid) begin
        sc_valid = ($urandom_range(0, 3) != 0);
        sc_ch = ($urandom_range(0, 40) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        chn = (sc_ch == 2'd3) ? 0 : int'(sc_ch);
        sc_rob = 3'((m_head[chn] + $urandom_range(0, 3)) % 8);
        sc_data = rnd_data();
      end
      rr = 3'($urandom_range(0, 7));
      #1;
      exp_rdy = (sc_ch == 2'd3) ? 1'b1 : !m_have[sc_ch][sc_rob];
      n_total++; if (sc_ready !== exp_rdy) $display("FAIL rnd_ready cyc %0d got %b exp %b", i, sc_ready, exp_rdy); else n_pass++;
      n_total++; if (err !== m_err) $display("FAIL rnd_err cyc %0d got %b exp %b", i, err, m_err); else n_pass++;
      for (int c = 0; c < 3; c++) begin
        n_total++; if (rv[c] !== m_have[c][m_head[c] % 8]) $display("FAIL rnd_valid ch%0d cyc %0d got %b exp %b", c, i, rv[c], m_have[c][m_head[c] % 8]); else n_pass++;
        n_total++; if (rob_o[c] !== 3'(m_head[c] % 8)) $display("FAIL rnd_rob ch%0d cyc %0d got %0d exp %0d", c, i, rob_o[c], m_head[c] % 8); else n_pass++;
        n_total++; if (cr[c] !== m_cred[c]) $display("FAIL rnd_credit ch%0d cyc %0d got %b exp %b", c, i, cr[c], m_cred[c]); else n_pass++;
        if (m_have[c][m_head[c] % 8]) begin
          n_total++; if (dat_o[c] !== m_dat[c][m_head[c] % 8]) $display("FAIL rnd_data ch%0d cyc %0d got %h exp %h", c, i, dat_o[c], m_dat[c][m_head[c] % 8]); else n_pass++;
        end
      end
      step();
    end
    sc_valid = 1'b0; rr = 3'b000;
  endtask

  task automatic test_reset_midop();
    int c0;
    apply_reset();
    rr = 3'b000;
    for (int i = 0; i < 3; i++) begin
      sc_valid = 1'b1; sc_ch = 2'd0; sc_rob = 3'(i); sc_data = rnd_data();
      step();
    end
    sc_valid = 1'b0;
    rr[0] = 1'b1;
    step();
    rr[0] = 1'b0;
    #1;
    n_total++; if (cr[0] !== 1'b1 || rob_o[0] !== 3'd1) $display("FAIL rmid_pending got cr=%b rob=%0d exp cr=1 rob=1", cr[0], rob_o[0]); else n_pass++;
    #1 rst_i = 1'b1;
    #1;
    n_total++; if (rv !== 3'b000) $display("FAIL rmid_valid got %b exp 000", rv); else n_pass++;
    n_total++; if (cr !== 3'b000) $display("FAIL rmid_credit got %b exp 000", cr); else n_pass++;
    n_total++; if (rob_o[0] !== 3'd0) $display("FAIL rmid_head got %0d exp 0", rob_o[0]); else n_pass++;
    n_total++; if (sc_ready !== 1'b0) $display("FAIL rmid_ready got %b exp 0", sc_ready); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    c0 = obs_cred[0];
    rr = 3'b111;
    repeat (3) step();
    n_total++; if (obs_cred[0] - c0 !== 0 || cr !== 3'b000) $display("FAIL rmid_no_credit got %0d pulses exp 0", obs_cred[0] - c0); else n_pass++;
    n_total++; if (rv !== 3'b000) $display("FAIL rmid_after_valid got %b exp 000", rv); else n_pass++;
    rr = 3'b000;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) obs_cred[c] = 0;
    model_reset();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_backpressure();
    test_wrap();
    test_illegal();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
